// File: rtl/serial_subtractor_pkg.sv
// Shared calculator definitions for the bit-serial subtractor: FSM encoding, default width
// and counter sizing. Optional feature macro: SERIAL_SUB_UNDERFLOW_EN.
package serial_subtractor_pkg;

  localparam int DEF_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed for a counter that must reach w-1.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus between the calculator controller
// (master) and the serial subtractor (slave).
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int n = DEF_WIDTH
) ();

  logic         start;
  logic [n-1:0] in1;
  logic [n-1:0] in2;
  logic         busy;
  logic         done;
  logic [n-1:0] diff;
  logic         underflow;

  modport master (
    output start, in1, in2,
    input  busy, done, diff, underflow
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, diff, underflow
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock with a registered borrow.
// Define SERIAL_SUB_UNDERFLOW_EN to register the final borrow onto the underflow output.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int n = DEF_WIDTH
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = cnt_width(n);

  state_t          state_q, state_d;
  logic [n-1:0]    a_q, b_q, res_q, diff_q, res_shift;
  logic [CW-1:0]   cnt_q;
  logic            borrow_q;
  logic            d_bit, bout;
  logic            accept, last;

  full_subtractor u_fs (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (borrow_q),
    .d   (d_bit),
    .bout(bout)
  );

  assign accept    = (state_q == IDLE) && bus.start;
  assign last      = (state_q == RUN) && (cnt_q == CW'(n - 1));
  // New bit enters at the MSB so that after n shifts bit 0 sits at the LSB.
  assign res_shift = (res_q >> 1) | ({{(n-1){1'b0}}, d_bit} << (n - 1));

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments for all registers so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      a_q      <= bus.in1;
      b_q      <= bus.in2;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
    end else if (state_q == RUN) begin
      a_q      <= a_q >> 1;
      b_q      <= b_q >> 1;
      res_q    <= res_shift;
      borrow_q <= bout;
      cnt_q    <= cnt_q + CW'(1);
      if (last) diff_q <= res_shift;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;

`ifdef SERIAL_SUB_UNDERFLOW_EN
  logic underflow_q;

  always_ff @(posedge clk) begin
    if (rst)       underflow_q <= 1'b0;
    else if (last) underflow_q <= bout;
  end

  assign bus.underflow = underflow_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && state_q == DONE && underflow_q) begin
      $display("underflow ERROR");
      $stop;
    end
  end
`endif
`else
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus randomized traffic,
// checked every cycle against a cycle-count model of the operation timeline.
module tb_serial_subtractor;

  localparam int N = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_subtractor_if #(.n(N)) sif ();

  serial_subtractor #(.n(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: cycles elapsed since acceptance (0 = idle). Result is plain modulo arithmetic.
  int           m_t   = 0;
  logic [N-1:0] m_res = '0;
  logic [N-1:0] m_diff = '0;
  logic         m_uf_pend = 1'b0;
  logic         m_uf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_t    <= 0;
      m_diff <= '0;
      m_uf   <= 1'b0;
    end else if (m_t == 0) begin
      if (sif.start) begin
        m_t       <= 1;
        m_res     <= N'(sif.in1 - sif.in2);
        m_uf_pend <= (sif.in1 < sif.in2);
      end
    end else if (m_t == N + 1) begin
      m_t <= 0;
    end else begin
      m_t <= m_t + 1;
      if (m_t == N) begin
        m_diff <= m_res;
`ifdef SERIAL_SUB_UNDERFLOW_EN
        m_uf   <= m_uf_pend;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", sif.busy, (m_t != 0));
      check("done", sif.done, (m_t == N + 1));
      check("diff", sif.diff, m_diff);
      check("underflow", sif.underflow, m_uf);
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    sif.in1   = a;
    sif.in2   = b;
    sif.start = 1'b1;
    cyc(1);
    sif.start = 1'b0;
  endtask

  // Returns at the negedge inside the DONE cycle (or after the budget expires).
  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sif.done) break;
    end
    check("done_wait", sif.done, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp);
    start_op(a, b);
    wait_done();
    check(name, sif.diff, exp);
    cyc(1);
  endtask

  initial begin
    sif.start = 1'b0;
    sif.in1   = '0;
    sif.in2   = '0;
    cyc(2);
    rst = 1'b0;
    check("rst_busy", sif.busy, 1'b0);
    check("rst_done", sif.done, 1'b0);
    check("rst_diff", sif.diff, 9'd0);
    check("rst_uf", sif.underflow, 1'b0);
    chk_en = 1'b1;

    // Basic and boundary operations with hand-computed results.
    run_op("basic_5_3", 9'd5, 9'd3, 9'd2);
    check("basic_busy_low", sif.busy, 1'b0);
    run_op("wrap_3_5", 9'd3, 9'd5, 9'h1FE);
    run_op("bnd_255_1", 9'd255, 9'd1, 9'd254);
    run_op("bnd_0_0", 9'd0, 9'd0, 9'd0);
    run_op("bnd_511_0", 9'd511, 9'd0, 9'd511);
    run_op("bnd_0_511", 9'd0, 9'd511, 9'd1);

    // Start while busy: at E3 and in the DONE cycle, both ignored.
    start_op(9'd10, 9'd4);
    cyc(2);
    sif.in1 = 9'd100; sif.in2 = 9'd1; sif.start = 1'b1;
    cyc(1);
    sif.start = 1'b0;
    wait_done();
    check("busy_ign_diff", sif.diff, 9'd6);
    sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    check("done_start_ign", sif.busy, 1'b0);
    run_op("after_busy", 9'd100, 9'd1, 9'd99);

    // Reset mid-operation: abort with no done pulse and diff cleared.
    start_op(9'd200, 9'd50);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("midrst_busy", sif.busy, 1'b0);
    check("midrst_diff", sif.diff, 9'd0);
    cyc(12);
    run_op("after_rst", 9'd7, 9'd7, 9'd0);

    // Reset and start on the same edge: reset wins.
    rst = 1'b1; sif.start = 1'b1; sif.in1 = 9'd9; sif.in2 = 9'd2;
    cyc(1);
    rst = 1'b0; sif.start = 1'b0;
    check("rst_prio_busy", sif.busy, 1'b0);
    cyc(2);
    check("rst_prio_idle", sif.busy, 1'b0);

    // Randomized traffic: random starts (often while busy), operands and rare resets.
    for (int i = 0; i < 600; i++) begin
      sif.start = ($urandom_range(0, 3) == 0);
      sif.in1   = N'($urandom);
      sif.in2   = N'($urandom);
      rst       = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    rst = 1'b0; sif.start = 1'b0;
    cyc(N + 4);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor for the calculator datapath. It computes `diff = in1 - in2` over n clock cycles, one bit per cycle, LSB first, using a registered borrow chain. It is the inverse-operation companion to the parallel registered adder and shares the same operand width and register style. A start/busy/done handshake lets the calculator controller launch an operation and collect a stable, registered result.

## Interface
- `n`, default 9: operand and result width in bits; legal range 2 to 32.
- `clk`, input, 1: single clock; all state updates on the posedge.
- `rst`, input, 1: synchronous, active-high reset, sampled on the posedge of `clk`.
- `start`, input, 1: request. It is accepted only when the state is IDLE.
- `in1`, input, n: minuend, unsigned. Captured on the accepting edge.
- `in2`, input, n: subtrahend, unsigned. Captured on the accepting edge.
- `busy`, output, 1: high in states RUN and DONE.
- `done`, output, 1: one-cycle pulse; `diff` and `underflow` are valid while it is high.
- `diff`, output, n: result `(in1 - in2) mod 2^n`. It holds its value until the next completion or reset.
- `underflow`, output, 1: high when `in1 < in2`. It holds its value like `diff`. Exists only under `SERIAL_SUB_UNDERFLOW_EN`; otherwise it is tied to 0.

## Operation
The block has three states: IDLE, RUN and DONE.
- **IDLE, `start`=1:** latch `in1` into shift register A and `in2` into shift register B. Clear the borrow, clear bit counter `cnt`, then go to RUN.
- **IDLE, `start`=0:** stay in IDLE.
- **RUN, each edge:**
  - d = A[0] ^ B[0] ^ borrow.
  - borrow' = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & borrow).
  - Shift d into the result register at the MSB end, shifting right.
  - Shift A and B right.
  - Increment `cnt`.
  - On the edge where `cnt` = n-1: go to DONE, load `diff` from the completed result, and load `underflow` from the final borrow'.
- **DONE:** `done`=1 for exactly one cycle. The next edge returns the block to IDLE unconditionally.
- **`start` outside IDLE:** ignored. It is neither queued nor errored.
- **Operand changes after acceptance:** `in1` and `in2` may change freely; they have no effect until the next accepted start.
- **Arithmetic:** pure modulo 2^n. There is no sign interpretation and no saturation.
- **Counter width:** `cnt` is wide enough to hold n-1.

## Timing
- **Acceptance:** the accepting edge is E0, with IDLE and `start`=1 sampled there.
- **Bit processing:** edges E1 through En process bits 0 through n-1.
- **Completion:** the state is DONE and `done`=1 during the cycle after En.
- **Return to IDLE:** En+1 returns the block to IDLE. A new start can be sampled at En+2 at the earliest, so throughput is one operation per n+2 cycles.
- **`busy`:** high from after E0 through the DONE cycle inclusive.
- **Reset values:**
  - State IDLE.
  - `busy`=0, `done`=0, `diff`=0, `underflow`=0.
  - Borrow 0, `cnt` 0, A=0, B=0.
- **Reset mid-operation:** abort immediately with all reset values. No partial result appears on `diff` and no `done` pulse is issued.
- **`rst` and `start` high on the same edge:** reset wins and the request is dropped.
- **Result visibility:** `diff` and `underflow` change only on the En edge or on reset, never during RUN.

## Configuration
- `SERIAL_SUB_UNDERFLOW_EN` defined:
  - The borrow-out is registered into `underflow` at En.
  - In simulation, a completed operation with `underflow`=1 prints "underflow ERROR" and calls `$stop`.
- Undefined:
  - No `underflow` register exists and the port drives constant 0.
  - No simulation check runs.
  - `diff` still wraps modulo 2^n.

## Structure
- **Shared calculator package/include:**
  - State encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default width constant 9.
  - Macro `SERIAL_SUB_UNDERFLOW_EN`.
- **Sub-module `full_subtractor`:** a combinational 1-bit cell with inputs a, b, bin and outputs d, bout. It is instantiated once and fed from A[0], B[0] and the borrow register.
- **Registers:** all registers live in the top module using non-blocking assignment.

## Test plan
All scenarios use n=9.
- **Basic subtraction:** `in1`=5, `in2`=3, `start` pulse at E0 → `done` high during the cycle after E9, `diff`=9'd2, `underflow`=0, `busy` low one cycle later.
- **Underflow:** `in1`=3, `in2`=5 → `diff`=9'h1FE.
  - With `SERIAL_SUB_UNDERFLOW_EN`: `underflow`=1 and the simulation stops.
  - Without it: `underflow`=0.
- **Boundary values:** `in1`=255, `in2`=1 → `diff`=254. Then `in1`=0, `in2`=0 → `diff`=0 and `underflow`=0.
- **Start while busy:**
  - Start A with 10−4.
  - Assert `start` with 100−1 at E3 and again in the DONE cycle.
  - Required: both are ignored, `diff`=6, and only one `done` pulse appears.
  - A start at En+2 is accepted, giving `diff`=99.
- **Reset mid-operation:**
  - Start with 200−50 and assert `rst` at E4.
  - Required: `busy`=0, `diff`=0, and no `done` pulse.
  - The next start with 7−7 completes normally with `diff`=0.
- **Reset priority:** `rst` and `start` both high on the same edge → the block remains IDLE and `busy` stays 0.
